// File: rtl/multicycle_control.sv
// Multicycle processor control unit: sequences FETCH/DECODE/EXEC/MEM/WB,
// decodes datapath controls from the current state and the latched opcode,
// counts retired instructions and traps memory waits that run too long.
module multicycle_control #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               branch,
  output logic               jump,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_to_reg,
  output logic               alu_src,
  output logic               reg_write,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               halt,
  output logic               busy,
  output logic               mem_error,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    OP_ALU_A  = 3'b000,
    OP_ALU_I  = 3'b001,
    OP_LOAD   = 3'b010,
    OP_STORE  = 3'b011,
    OP_BRANCH = 3'b100,
    OP_JAL    = 3'b101,
    OP_JALR   = 3'b110,
    OP_HALT   = 3'b111
  } opcode_t;

  // The wait counter only ever needs to reach MEM_TIMEOUT-1 before the
  // trap fires, so it is sized for that value.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            r_state;
  opcode_t           r_op_q;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_count;

  logic              w_waiting;
  logic              w_timeout;
  logic [2:0]        w_alu_code;
  logic              w_alu_src;

  // ALU operation code used while the instruction executes.
  function automatic logic [2:0] alu_code(input opcode_t op);
    case (op)
      OP_ALU_I:  return 3'd1;
      OP_LOAD:   return 3'd3;
      OP_STORE:  return 3'd5;
      OP_BRANCH: return 3'd6;
      OP_JALR:   return 3'd7;
      default:   return 3'd0;
    endcase
  endfunction

  // Second ALU operand comes from the immediate for these instructions.
  function automatic logic uses_imm(input opcode_t op);
    return (op == OP_ALU_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JALR);
  endfunction

  assign w_alu_code = alu_code(r_op_q);
  assign w_alu_src  = uses_imm(r_op_q);
  assign w_waiting  = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
  // A completing handshake on the last allowed cycle wins over the trap.
  assign w_timeout  = TIMEOUT_EN && w_waiting && (r_wait == WAIT_LAST);

  // State sequencing, opcode latch, memory wait counter and retire counter.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking = would let later lines see new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op_q  <= OP_ALU_A;
      r_wait  <= '0;
      r_count <= '0;
    end else begin
      r_wait <= w_waiting ? r_wait + 1'b1 : '0;
      if (pc_write) r_count <= r_count + 1'b1;

      case (r_state)
        S_IDLE:   if (start) r_state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready)      r_state <= S_DECODE;
          else if (w_timeout) r_state <= S_ERROR;
        end
        S_DECODE: begin
          r_op_q  <= opcode_t'(opcode);
          r_state <= (opcode_t'(opcode) == OP_HALT) ? S_HALTED : S_EXEC;
        end
        S_EXEC: begin
          case (r_op_q)
            OP_BRANCH:         r_state <= S_FETCH;
            OP_LOAD, OP_STORE: r_state <= S_MEM;
            default:           r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready)      r_state <= (r_op_q == OP_STORE) ? S_FETCH : S_WB;
          else if (w_timeout) r_state <= S_ERROR;
        end
        S_WB:     r_state <= S_FETCH;
        default:  r_state <= r_state;  // HALTED and ERROR leave only via reset
      endcase
    end
  end

  // Datapath controls decoded from state and latched opcode; the two
  // handshake-completion strobes follow mem_ready in the same cycle.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    alu_op     = '0;
    halt       = 1'b0;
    mem_error  = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      S_EXEC: begin
        alu_op  = ALUOP_W'(w_alu_code);
        alu_src = w_alu_src;
        if (r_op_q == OP_BRANCH) begin
          branch   = 1'b1;
          pc_write = 1'b1;
        end
        jump = (r_op_q == OP_JAL);
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (r_op_q == OP_STORE);
        alu_op   = ALUOP_W'(w_alu_code);
        alu_src  = w_alu_src;
        pc_write = (r_op_q == OP_STORE) && mem_ready;
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = (r_op_q == OP_LOAD);
        jump       = (r_op_q == OP_JAL);
      end
      S_HALTED: halt = 1'b1;
      S_ERROR: begin
        halt      = 1'b1;
        mem_error = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy        = (r_state != S_IDLE) && (r_state != S_HALTED) && (r_state != S_ERROR);
  assign state       = r_state;
  assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and randomized instruction streams
// checked cycle by cycle against a per-instruction trace model.
module tb_multicycle_control;
  localparam int ALUOP_W = 4;
  localparam int TMO     = 4;
  localparam int CNT_W   = 2;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [2:0]         opcode;
  logic               mem_ready;
  logic               pc_write, ir_write, branch, jump, mem_req, mem_we;
  logic               mem_to_reg, alu_src, reg_write, halt, busy, mem_error;
  logic [ALUOP_W-1:0] alu_op;
  logic [2:0]         state;
  logic [CNT_W-1:0]   instr_count;

  int checks   = 0;
  int failures = 0;
  int m_count  = 0;  // retired instructions since last reset

  multicycle_control #(.ALUOP_W(ALUOP_W), .MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .branch(branch), .jump(jump),
    .mem_req(mem_req), .mem_we(mem_we), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .reg_write(reg_write), .alu_op(alu_op), .halt(halt), .busy(busy),
    .mem_error(mem_error), .state(state), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ctl(input bit pcw, irw, br, jmp, mreq, mwe,
                                      m2r, asrc, rw, hlt, bsy, merr);
    return {pcw, irw, br, jmp, mreq, mwe, m2r, asrc, rw, hlt, bsy, merr};
  endfunction

  function automatic int exp_alu(input int op);
    case (op)
      1: return 1;
      2: return 3;
      3: return 5;
      4: return 6;
      6: return 7;
      default: return 0;
    endcase
  endfunction

  function automatic bit exp_src(input int op);
    return op == 1 || op == 2 || op == 3 || op == 4 || op == 6;
  endfunction

  // One clock cycle: inputs already driven; check at negedge, then advance.
  task automatic cyc(input string tag, input int st, input logic [11:0] c, input int alu);
    @(negedge clk);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".ctl"}, 32'({pc_write, ir_write, branch, jump, mem_req, mem_we,
                            mem_to_reg, alu_src, reg_write, halt, busy, mem_error}),
        32'(c));
    chk({tag, ".alu_op"}, 32'(alu_op), 32'(alu));
    chk({tag, ".count"}, 32'(instr_count), 32'(m_count % (1 << CNT_W)));
    @(posedge clk);
    if (c[11]) m_count++;
    #1;
  endtask

  task automatic error_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b1;
      mem_ready = 1'(($urandom));
      cyc("error", 7, ctl(0,0,0,0,0,0,0,0,0,1,0,1), 0);
    end
    start = 1'b0;
  endtask

  // Runs one instruction starting in FETCH. fw/mw are wait cycles before
  // mem_ready; a value >= TMO means memory never answers.
  task automatic run_instr(input int op, input int fw, input int mw);
    int alu;
    bit src;
    start = 1'($urandom);
    if (fw >= TMO) begin
      for (int i = 0; i < TMO; i++) begin
        mem_ready = 1'b0;
        opcode = 3'($urandom);
        cyc("fetch_to", 1, ctl(0,0,0,0,1,0,0,0,0,0,1,0), 0);
      end
      error_cycles(2);
      return;
    end
    for (int i = 0; i <= fw; i++) begin
      mem_ready = (i == fw);
      opcode = 3'($urandom);
      cyc("fetch", 1, ctl(0,i==fw,0,0,1,0,0,0,0,0,1,0), 0);
    end
    opcode = 3'(op);
    mem_ready = 1'($urandom);
    cyc("decode", 2, ctl(0,0,0,0,0,0,0,0,0,0,1,0), 0);
    opcode = 3'($urandom);
    if (op == 7) begin
      cyc("halted", 6, ctl(0,0,0,0,0,0,0,0,0,1,0,0), 0);
      return;
    end
    alu = exp_alu(op);
    src = exp_src(op);
    mem_ready = 1'($urandom);
    cyc("exec", 3, ctl(op==4,0,op==4,op==5,0,0,0,src,0,0,1,0), alu);
    if (op == 2 || op == 3) begin
      if (mw >= TMO) begin
        for (int i = 0; i < TMO; i++) begin
          mem_ready = 1'b0;
          cyc("mem_to", 4, ctl(0,0,0,0,1,op==3,0,src,0,0,1,0), alu);
        end
        error_cycles(2);
        return;
      end
      for (int i = 0; i <= mw; i++) begin
        mem_ready = (i == mw);
        cyc("mem", 4, ctl(op==3 && i==mw,0,0,0,1,op==3,0,src,0,0,1,0), alu);
      end
    end
    if (op != 3 && op != 4) begin
      mem_ready = 1'($urandom);
      cyc("wb", 5, ctl(1,0,0,op==5,0,0,op==2,0,1,0,1,0), 0);
    end
  endtask

  task automatic check_idle_now(input string tag);
    chk({tag, ".state"}, 32'(state), 32'd0);
    chk({tag, ".ctl"}, 32'({pc_write, ir_write, branch, jump, mem_req, mem_we,
                            mem_to_reg, alu_src, reg_write, halt, busy, mem_error}), 32'd0);
    chk({tag, ".alu_op"}, 32'(alu_op), 32'd0);
    chk({tag, ".count"}, 32'(instr_count), 32'd0);
  endtask

  // Reset asynchronously in mid-cycle, then release just after an edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_now(tag);
    m_count = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic go();
    start = 1'b1;
    mem_ready = 1'($urandom);
    cyc("idle_start", 0, 12'd0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    opcode = 3'd0;
    mem_ready = 1'b0;
    #12;
    check_idle_now("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // IDLE holds without start, whatever else toggles.
    for (int i = 0; i < 2; i++) begin
      start = 1'b0;
      opcode = 3'($urandom);
      mem_ready = 1'($urandom);
      cyc("idle", 0, 12'd0, 0);
    end

    go();
    run_instr(1, 0, 0);             // ALU_I basic flow
    run_instr(2, 0, 3);             // LOAD with 3 memory wait cycles
    run_instr(3, 1, 2);             // STORE, no WB
    for (int i = 0; i < 5; i++)     // BRANCH x5: counter wraps at CNT_W=2
      run_instr(4, 0, 0);
    run_instr(5, 2, 0);             // JAL
    run_instr(6, 0, 0);             // JALR
    run_instr(0, TMO - 1, 0);       // ready on last allowed fetch cycle
    run_instr(2, 0, TMO - 1);       // ready on last allowed mem cycle

    for (int n = 0; n < 25; n++)
      run_instr($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3));

    // HALT: stays halted, start pulses ignored.
    run_instr(7, 1, 0);
    for (int i = 0; i < 3; i++) begin
      start = 1'(i % 2 == 0);
      mem_ready = 1'($urandom);
      cyc("halted_hold", 6, ctl(0,0,0,0,0,0,0,0,0,1,0,0), 0);
    end
    do_reset("rst_halted");

    // Reset during a fetch wait.
    go();
    start = 1'b0;
    mem_ready = 1'b0;
    cyc("fetch_wait", 1, ctl(0,0,0,0,1,0,0,0,0,0,1,0), 0);
    do_reset("rst_mid_fetch");
    start = 1'b0;
    cyc("idle_after_rst", 0, 12'd0, 0);

    // Fetch timeout traps into ERROR.
    go();
    run_instr(0, TMO, 0);
    do_reset("rst_err_fetch");

    // Memory-phase timeout on LOAD and on STORE.
    go();
    run_instr(1, 0, 0);
    run_instr(2, 0, TMO);
    do_reset("rst_err_load");
    go();
    run_instr(3, 1, TMO);
    do_reset("rst_err_store");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALUOP_W, default 3: width of alu_op; SHALL be >= 3.
REQ-002 Parameter MEM_TIMEOUT, default 15: max wait cycles on mem_ready; 0 disables timeout.
REQ-003 Parameter CNT_W, default 16: width of instr_count.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin execution from IDLE.
REQ-007 opcode  in  3  instruction opcode; 000 ALU_A, 001 ALU_I, 010 LOAD, 011 STORE, 100 BRANCH, 101 JAL, 110 JALR, 111 HALT.
REQ-008 mem_ready  in  1  memory completes the current request this cycle.
REQ-009 pc_write, ir_write, branch, jump, mem_req, mem_we, mem_to_reg, alu_src, reg_write  out  1 each  datapath controls.
REQ-010 alu_op  out  ALUOP_W  ALU operation code, zero-extended.
REQ-011 halt  out  1  processor stopped; busy  out  1  state not IDLE/HALTED/ERROR.
REQ-012 mem_error  out  1  sticky memory-timeout flag; state  out  3  current state encoding.
REQ-013 instr_count  out  CNT_W  retired-instruction count.

Function
REQ-014 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6, ERROR=7.
REQ-015 All outputs SHALL be Moore: decoded from state and the opcode latched in DECODE (op_q); the opcode input is sampled only in DECODE.
REQ-016 IDLE: all controls 0; start=1 -> FETCH next cycle; else stay.
REQ-017 FETCH: mem_req=1, mem_we=0; mem_ready=1 -> ir_write=1 same cycle, next DECODE.
REQ-018 DECODE: op_q <= opcode; HALT -> HALTED; any other opcode -> EXEC.
REQ-019 EXEC alu_op: ALU_A 0, ALU_I 1, LOAD 3, STORE 5, BRANCH 6, JALR 7, JAL 0; alu_src=1 for ALU_I/LOAD/STORE/BRANCH/JALR, else 0.
REQ-020 EXEC: BRANCH -> branch=1, pc_write=1, next FETCH; JAL -> jump=1, next WB; LOAD/STORE -> MEM; ALU_A/ALU_I/JALR -> WB.
REQ-021 MEM: mem_req=1, mem_we=1 only for STORE, alu_op/alu_src held from EXEC; on mem_ready LOAD -> WB, STORE -> pc_write=1, next FETCH.
REQ-022 WB: reg_write=1, pc_write=1, mem_to_reg=1 only for LOAD, jump=1 held for JAL; next FETCH.
REQ-023 instr_count SHALL increment by 1 on every cycle pc_write=1, wrapping from all-ones to 0.
REQ-024 Wait counter SHALL clear on entry to FETCH/MEM and increment each cycle there with mem_ready=0.
REQ-025 MEM_TIMEOUT>0 and counter reaching MEM_TIMEOUT with mem_ready=0 -> ERROR next cycle; mem_ready=1 on that same cycle wins (normal completion).
REQ-026 HALTED: halt=1, all other controls 0, start ignored; exit only via reset.
REQ-027 ERROR: halt=1, mem_error=1, other controls 0; exit only via reset.
REQ-028 start is ignored in every state except IDLE.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, op_q 0, wait counter 0, instr_count 0 and all outputs 0, including mid-memory-wait.
REQ-030 First state change after rst_n deasserts SHALL occur on a rising clk edge.

Verification
REQ-031 Reset, start=1, opcode=001, mem_ready=1 -> states 1,2,3,5,1; WB has reg_write=1, pc_write=1; alu_op=1, alu_src=1 in EXEC; instr_count=1.
REQ-032 LOAD with mem_ready held 0 for 3 MEM cycles, then 1 -> mem_req=1 for 4 cycles, mem_we=0, then WB with mem_to_reg=1.
REQ-033 STORE -> MEM with mem_we=1, alu_op=5; on mem_ready, pc_write=1, next FETCH, no WB, reg_write never 1.
REQ-034 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> ERROR after 4 wait cycles, halt=1, mem_error=1; mem_ready=1 on 4th cycle -> DECODE instead.
REQ-035 opcode=111 -> HALTED after DECODE, halt=1; start pulses ignored; rst_n=0 mid-FETCH -> IDLE, outputs 0 asynchronously.
REQ-036 CNT_W=2, 5 BRANCH instructions -> instr_count 1,2,3,0,1.
